// File: rtl/fsm_ctrl_gen.sv
// Run/pause, direction and single-step controller for a downstream sequence FSM.
// Three raw buttons are synchronized and debounced into one-cycle press events that drive a run FSM and prescaler.
module fsm_ctrl_gen #(
    parameter int DIV       = 50_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_dir,
    input  logic btn_step,
    output logic enable,
    output logic up_down,
    output logic running
);

    localparam int DBW = $clog2(DB_CYCLES);
    localparam int PW  = $clog2(DIV);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [PW-1:0]  DIV_LAST = PW'(DIV - 1);

    localparam int RUN_I  = 0;
    localparam int DIR_I  = 1;
    localparam int STEP_I = 2;

    typedef enum logic [1:0] {STABLE_LOW, CHK_HIGH, STABLE_HIGH, CHK_LOW} db_state_t;
    typedef enum logic {PAUSED, RUNNING} run_state_t;

    logic [2:0]     btn_raw;
    logic [2:0]     sync_p0;
    logic [2:0]     sync_p1;
    db_state_t      db_q   [3];
    db_state_t      db_d   [3];
    logic [DBW-1:0] cnt_q  [3];
    logic [DBW-1:0] cnt_d  [3];
    logic [2:0]     press_d;
    logic [2:0]     press_q;

    run_state_t     run_q;
    run_state_t     run_d;
    logic [PW-1:0]  presc_q;
    logic [PW-1:0]  presc_d;
    logic           en_d;
    logic           ud_d;

    assign btn_raw = {btn_step, btn_dir, btn_run};

    // Stage p0/p1: two-flop synchronizers, then debouncer state and press events
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_q[i]  <= STABLE_LOW;
                cnt_q[i] <= '0;
            end
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            press_q <= press_d;
            for (int i = 0; i < 3; i++) begin
                db_q[i]  <= db_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        press_d = '0;
        for (int i = 0; i < 3; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = cnt_q[i];
            case (db_q[i])
                STABLE_LOW: begin
                    if (sync_p1[i]) begin
                        db_d[i]  = CHK_HIGH;
                        cnt_d[i] = '0;
                    end
                end
                CHK_HIGH: begin
                    if (!sync_p1[i]) begin
                        db_d[i] = STABLE_LOW;
                    end else if (cnt_q[i] == DB_LAST) begin
                        db_d[i]    = STABLE_HIGH;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync_p1[i]) begin
                        db_d[i]  = CHK_LOW;
                        cnt_d[i] = '0;
                    end
                end
                CHK_LOW: begin
                    // Releases are debounced too, but never raise an event
                    if (sync_p1[i]) begin
                        db_d[i] = STABLE_HIGH;
                    end else if (cnt_q[i] == DB_LAST) begin
                        db_d[i] = STABLE_LOW;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: db_d[i] = STABLE_LOW;
            endcase
        end
    end

    // Stage p2: run FSM, prescaler and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_q   <= PAUSED;
            presc_q <= '0;
            enable  <= 1'b0;
            up_down <= 1'b1;
            running <= 1'b0;
        end else begin
            run_q   <= run_d;
            presc_q <= presc_d;
            enable  <= en_d;
            up_down <= ud_d;
            running <= (run_d == RUNNING);
        end
    end

    always_comb begin
        run_d   = run_q;
        presc_d = presc_q;
        en_d    = 1'b0;
        ud_d    = press_q[DIR_I] ? ~up_down : up_down;
        case (run_q)
            PAUSED: begin
                presc_d = '0;
                if (press_q[RUN_I]) begin
                    run_d = RUNNING;
                end else if (press_q[STEP_I]) begin
                    en_d = 1'b1;
                end
            end
            RUNNING: begin
                // A pause wins over a pulse that was due on the same edge
                if (press_q[RUN_I]) begin
                    run_d   = PAUSED;
                    presc_d = '0;
                end else if (presc_q == DIV_LAST) begin
                    presc_d = '0;
                    en_d    = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: run_d = PAUSED;
        endcase
    end

endmodule

// File: tb/tb_fsm_ctrl_gen.sv
// Scoreboard bench for fsm_ctrl_gen with DIV=4, DB_CYCLES=3: a timeline of button presses,
// with expected {enable,up_down,running} per cycle queued as stimulus is driven and popped each cycle.
module tb_fsm_ctrl_gen;

    localparam int DIV = 4;
    localparam int DB  = 3;
    localparam int LAT = DB + 4;      // raw first sampled at edge k+1 -> output changes at edge k+LAT
    localparam int HOLD = 10;

    localparam int RST_REL  = 5;
    localparam int K_RUN1   = 25;
    localparam int K_DIR1   = 46;
    localparam int K_DIR2   = 62;
    localparam int K_STEP1  = 74;
    localparam int K_RUN2   = 93;     // chosen so the pause lands on a due pulse
    localparam int K_GLITCH = 110;
    localparam int K_STEP2  = 125;
    localparam int K_RUN3   = 145;
    localparam int K_DIR3   = 160;
    localparam int K_DIR4   = 175;    // held across the mid-run reset
    localparam int RST_AT   = 181;
    localparam int K_DIR4_REL = 195;
    localparam int END_CYC  = 210;

    localparam int E1 = K_RUN1 + LAT;
    localparam int P1 = K_RUN2 + LAT;
    localparam int S1 = K_STEP2 + LAT;
    localparam int E2 = K_RUN3 + LAT;
    localparam int T1 = K_DIR1 + LAT;
    localparam int T2 = K_DIR2 + LAT;
    localparam int T3 = K_DIR3 + LAT;
    localparam int T4 = RST_AT + LAT;

    logic clk = 1'b0;
    logic rst;
    logic btn_run, btn_dir, btn_step;
    logic enable, up_down, running;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [2:0] val;
    } exp_t;

    exp_t sb[$];

    fsm_ctrl_gen #(.DIV(DIV), .DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_run  (btn_run),
        .btn_dir  (btn_dir),
        .btn_step (btn_step),
        .enable   (enable),
        .up_down  (up_down),
        .running  (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Expected {enable, up_down, running} after edge c for the timeline above
    function automatic logic [2:0] exp_out(input int c);
        logic en, ud, run;
        run = (c >= E1 && c < P1) || (c >= E2 && c < RST_AT);
        en  = (c > E1 && c < P1 && (c - E1) % DIV == 0) || (c == S1) ||
              (c > E2 && c < RST_AT && (c - E2) % DIV == 0);
        ud  = !((c >= T1 && c < T2) || (c >= T3 && c < RST_AT) || (c >= T4));
        return {en, ud, run};
    endfunction

    task automatic plan(input string phase, input int from, input int to);
        exp_t e;
        for (int c = from; c <= to; c++) begin
            e.cyc = c;
            e.tag = $sformatf("%s@c%0d {en,ud,run}", phase, c);
            e.val = exp_out(c);
            sb.push_back(e);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc == cyc) chk(e.tag, int'({enable, up_down, running}), int'(e.val));
            else chk($sformatf("sb_order@c%0d", cyc), e.cyc, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(negedge clk);
            compare_front();
        end
    endtask

    task automatic step_to(input string phase, input int c);
        plan(phase, cyc + 1, c);
        wait_until(c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish by cycle %0d", END_CYC);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b0;
        btn_run = 1'b0;
        btn_dir = 1'b0;
        btn_step = 1'b0;

        step_to("reset", RST_REL);
        rst = 1'b1;
        step_to("idle", K_RUN1);

        btn_run = 1'b1;
        step_to("run_press", K_RUN1 + HOLD);
        btn_run = 1'b0;
        step_to("running", K_DIR1);

        btn_dir = 1'b1;
        step_to("dir1", K_DIR1 + HOLD);
        btn_dir = 1'b0;
        step_to("dir1_rel", K_DIR2);
        btn_dir = 1'b1;
        step_to("dir2", K_DIR2 + HOLD);
        btn_dir = 1'b0;
        step_to("dir2_rel", K_STEP1);

        btn_step = 1'b1;
        step_to("step_running", K_STEP1 + HOLD);
        btn_step = 1'b0;
        step_to("step_rel", K_RUN2);

        btn_run = 1'b1;
        step_to("pause_due", K_RUN2 + HOLD);
        btn_run = 1'b0;
        step_to("paused", K_GLITCH);

        btn_run = 1'b1;
        step_to("glitch", K_GLITCH + 2);
        btn_run = 1'b0;
        step_to("glitch_rel", K_STEP2);

        btn_step = 1'b1;
        step_to("step_paused", K_STEP2 + HOLD);
        btn_step = 1'b0;
        step_to("step_rel2", K_RUN3);

        btn_run = 1'b1;
        step_to("run_again", K_RUN3 + HOLD);
        btn_run = 1'b0;
        step_to("running2", K_DIR3);

        btn_dir = 1'b1;
        step_to("dir3", K_DIR3 + HOLD);
        btn_dir = 1'b0;
        step_to("dir3_rel", K_DIR4);

        btn_dir = 1'b1;
        step_to("dir4_held", RST_AT - 1);
        rst = 1'b0;
        step_to("mid_reset", RST_AT);
        rst = 1'b1;
        step_to("post_reset", K_DIR4_REL);
        btn_dir = 1'b0;
        step_to("tail", END_CYC);

        @(negedge clk);
        compare_front();
        chk("sb_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
